rd_deserializer: RTL and testbench

RD_DESERIALIZER -- requirements
Module: rd_deserializer

---
 rtl/rd_deserializer.sv | 157 +++++++++++++++
 tb/tb_rd_deserializer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_deserializer.sv
// Two-channel 12-bit serial word deserializer writing {ch1, ch0} words into a capture memory.
// Parity checking and error counting are enabled by defining RD_PARITY_CHECK_EN.
module rd_deserializer #(
    parameter int unsigned MEM_SIZE = 2048
) (
    input  logic        LOCAL_CLK,
    input  logic        RST_N,
    input  logic        ENABLE,
    input  logic        XFR_EN,
    input  logic        SERIAL_IN0,
    input  logic        SERIAL_IN1,
    output logic [10:0] WRT_ADDR,
    output logic [23:0] WRT_DATA,
    output logic        WE,
    output logic [1:0]  PAR_ERR,
    output logic        BUSY,
    output logic        DONE,
    output logic        PARTIAL,
    output logic [11:0] WORD_COUNT,
    output logic [11:0] ERR_COUNT0,
    output logic [11:0] ERR_COUNT1
);

    localparam int unsigned DATA_W   = 12;
    localparam int unsigned CNT_W    = 12;
    localparam int unsigned ADDR_W   = 11;
    localparam int unsigned BITCNT_W = 4;

    localparam logic [BITCNT_W-1:0] PARITY_SLOT = BITCNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]    MEM_LIMIT   = CNT_W'(MEM_SIZE);
    localparam logic [CNT_W-1:0]    CNT_MAX     = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FULL   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   sr0;
    logic [DATA_W-1:0]   sr1;
    logic [BITCNT_W-1:0] bit_cnt;
    logic [1:0]          par_err_c;
    logic [CNT_W-1:0]    word_count_inc_c;

    // Odd parity over the 12 data bits plus the parity bit currently on the wire.
    always_comb begin
        par_err_c = '0;
`ifdef RD_PARITY_CHECK_EN
        par_err_c[0] = ~(^{sr0, SERIAL_IN0});
        par_err_c[1] = ~(^{sr1, SERIAL_IN1});
`endif
        word_count_inc_c = WORD_COUNT + CNT_W'(1);
    end

    always_ff @(posedge LOCAL_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            sr0        <= '0;
            sr1        <= '0;
            bit_cnt    <= '0;
            WRT_ADDR   <= '0;
            WRT_DATA   <= '0;
            WE         <= 1'b0;
            PAR_ERR    <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            PARTIAL    <= 1'b0;
            WORD_COUNT <= '0;
            ERR_COUNT0 <= '0;
            ERR_COUNT1 <= '0;
        end else begin
            WE   <= 1'b0;
            DONE <= 1'b0;

            // Address advances after every write strobe; wraps naturally at 2048.
            if (WE) begin
                WRT_ADDR <= WRT_ADDR + ADDR_W'(1);
            end

            if (!ENABLE) begin
                // Software disarm: silent abort, counters keep their values.
                state   <= IDLE;
                BUSY    <= 1'b0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (XFR_EN) begin
                            state      <= SHIFT;
                            BUSY       <= 1'b1;
                            sr0        <= DATA_W'(SERIAL_IN0);
                            sr1        <= DATA_W'(SERIAL_IN1);
                            bit_cnt    <= BITCNT_W'(1);
                            WRT_ADDR   <= '0;
                            WORD_COUNT <= '0;
                            ERR_COUNT0 <= '0;
                            ERR_COUNT1 <= '0;
                            PARTIAL    <= 1'b0;
                        end
                    end

                    SHIFT: begin
                        if (!XFR_EN) begin
                            state   <= FINISH;
                            BUSY    <= 1'b0;
                            DONE    <= 1'b1;
                            bit_cnt <= '0;
                            if (bit_cnt != '0) begin
                                PARTIAL <= 1'b1;
                            end
                        end else if (bit_cnt == PARITY_SLOT) begin
                            // Parity slot: the 12 data bits are complete, emit the word.
                            WE         <= 1'b1;
                            WRT_DATA   <= {sr1, sr0};
                            PAR_ERR    <= par_err_c;
                            WORD_COUNT <= word_count_inc_c;
                            bit_cnt    <= '0;
                            if (par_err_c[0] && (ERR_COUNT0 != CNT_MAX)) begin
                                ERR_COUNT0 <= ERR_COUNT0 + CNT_W'(1);
                            end
                            if (par_err_c[1] && (ERR_COUNT1 != CNT_MAX)) begin
                                ERR_COUNT1 <= ERR_COUNT1 + CNT_W'(1);
                            end
                            if (word_count_inc_c == MEM_LIMIT) begin
                                state <= FULL;
                            end
                        end else begin
                            sr0     <= {sr0[DATA_W-2:0], SERIAL_IN0};
                            sr1     <= {sr1[DATA_W-2:0], SERIAL_IN1};
                            bit_cnt <= bit_cnt + BITCNT_W'(1);
                        end
                    end

                    FULL: begin
                        if (!XFR_EN) begin
                            state <= FINISH;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                        end
                    end

                    FINISH: begin
                        state <= IDLE;
                    end

                    default: begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rd_deserializer.sv
// Randomized scoreboard bench for rd_deserializer; expected writes come from a word-level model.
`timescale 1ns/1ps
module tb_rd_deserializer;

    localparam int unsigned MEM_SIZE = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        xfr_en = 1'b0;
    logic        s0 = 1'b1;
    logic        s1 = 1'b1;
    logic [10:0] wrt_addr;
    logic [23:0] wrt_data;
    logic        we;
    logic [1:0]  par_err;
    logic        busy;
    logic        done;
    logic        partial;
    logic [11:0] word_count;
    logic [11:0] err_count0;
    logic [11:0] err_count1;

    always #5 clk = ~clk;

    rd_deserializer #(.MEM_SIZE(MEM_SIZE)) dut (
        .LOCAL_CLK  (clk),
        .RST_N      (rst_n),
        .ENABLE     (enable),
        .XFR_EN     (xfr_en),
        .SERIAL_IN0 (s0),
        .SERIAL_IN1 (s1),
        .WRT_ADDR   (wrt_addr),
        .WRT_DATA   (wrt_data),
        .WE         (we),
        .PAR_ERR    (par_err),
        .BUSY       (busy),
        .DONE       (done),
        .PARTIAL    (partial),
        .WORD_COUNT (word_count),
        .ERR_COUNT0 (err_count0),
        .ERR_COUNT1 (err_count1)
    );

    typedef struct packed {
        logic [10:0] addr;
        logic [23:0] data;
        logic [1:0]  perr;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [11:0] w0_q[$];
    logic [11:0] w1_q[$];
    logic [1:0]  flip_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", 32'(we), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wrt_addr", 32'(wrt_addr), 32'(mon_e.addr));
                check("wrt_data", 32'(wrt_data), 32'(mon_e.data));
                check("par_err",  32'(par_err),  32'(mon_e.perr));
            end
        end
    end

    task automatic add_word(input logic [11:0] a0, input logic [11:0] a1, input logic [1:0] flip);
        w0_q.push_back(a0);
        w1_q.push_back(a1);
        flip_q.push_back(flip);
    endtask

    task automatic add_random_words(input int n);
        for (int i = 0; i < n; i++) begin
            logic [1:0] f;
            f = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            add_word(12'($urandom), 12'($urandom), f);
        end
    endtask

    // Model the queued words, push expected writes, then serialize them onto the channels.
    task automatic push_and_drive(input int extra_bits, output int nwr, output int e0, output int e1);
        logic [12:0] fr0[$];
        logic [12:0] fr1[$];
        int          nw;
        nw  = w0_q.size();
        nwr = (nw < int'(MEM_SIZE)) ? nw : int'(MEM_SIZE);
        e0  = 0;
        e1  = 0;
        for (int i = 0; i < nw; i++) begin
            logic p0, p1;
            wr_t  e;
            p0 = ~(^w0_q[i]) ^ flip_q[i][0];
            p1 = ~(^w1_q[i]) ^ flip_q[i][1];
            fr0.push_back({w0_q[i], p0});
            fr1.push_back({w1_q[i], p1});
            if (i < nwr) begin
                e.addr = 11'(i % 2048);
                e.data = {w1_q[i], w0_q[i]};
                e.perr = 2'b00;
`ifdef RD_PARITY_CHECK_EN
                e.perr[0] = ~(^{w0_q[i], p0});
                e.perr[1] = ~(^{w1_q[i], p1});
`endif
                e0 += int'(e.perr[0]);
                e1 += int'(e.perr[1]);
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < nw; i++) begin
            for (int b = 12; b >= 0; b--) begin
                @(negedge clk);
                xfr_en = 1'b1;
                s0 = fr0[i][b];
                s1 = fr1[i][b];
            end
        end
        for (int k = 0; k < extra_bits; k++) begin
            @(negedge clk);
            xfr_en = 1'b1;
            s0 = 1'($urandom);
            s1 = 1'($urandom);
        end
        w0_q.delete();
        w1_q.delete();
        flip_q.delete();
    endtask

    // Full transfer ending with XFR_EN low; also pokes XFR_EN during FINISH.
    task automatic run_transfer(input int extra_bits, input bit extra_ones);
        int nwr, e0, e1, d0;
        bit full;
        d0 = done_cnt;
        full = (w0_q.size() >= int'(MEM_SIZE));
        if (extra_ones) begin
            push_and_drive(0, nwr, e0, e1);
            for (int k = 0; k < extra_bits; k++) begin
                @(negedge clk);
                xfr_en = 1'b1; s0 = 1'b1; s1 = 1'b1;
            end
        end else begin
            push_and_drive(extra_bits, nwr, e0, e1);
        end
        @(negedge clk);
        xfr_en = 1'b0; s0 = 1'b1; s1 = 1'b1;
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_finish", 32'(busy), 32'd0);
        xfr_en = 1'b1;
        @(negedge clk);
        check("done_width", 32'(done), 32'd0);
        check("finish_restart_ignored", 32'(busy), 32'd0);
        xfr_en = 1'b0;
        @(negedge clk);
        check("busy_idle", 32'(busy), 32'd0);
        check("word_count", 32'(word_count), 32'(nwr));
        check("partial", 32'(partial), 32'(!full && (extra_bits % 13 != 0)));
        check("err_count0", 32'(err_count0), 32'(e0));
        check("err_count1", 32'(err_count1), 32'(e1));
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(done_cnt - d0), 32'd1);
    endtask

    // Ten words plus part of word 10, then abort with ENABLE or RST_N; restart must use address 0.
    task automatic abort_test(input bit use_rst);
        int nwr, e0, e1, d0;
        add_random_words(10);
        d0 = done_cnt;
        push_and_drive(5, nwr, e0, e1);
        check("abort_drained", 32'(exp_q.size()), 32'd0);
        if (use_rst) begin
            @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_word_count", 32'(word_count), 32'd0);
            check("rst_partial", 32'(partial), 32'd0);
            @(negedge clk);
            xfr_en = 1'b0;
            rst_n = 1'b1;
        end else begin
            @(negedge clk);
            enable = 1'b0;
            @(negedge clk);
            check("dis_busy", 32'(busy), 32'd0);
            check("dis_we", 32'(we), 32'd0);
            check("dis_word_count_hold", 32'(word_count), 32'd10);
            @(negedge clk);
            xfr_en = 1'b0;
            @(negedge clk);
            enable = 1'b1;
        end
        @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        add_random_words(2);
        run_transfer(0, 1'b0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_we", 32'(we), 32'd0);
        check("rst_busy0", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(wrt_addr), 32'd0);
        check("rst_data", 32'(wrt_data), 32'd0);
        check("rst_cnts", 32'({err_count0, err_count1, par_err, partial}), 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);

        add_word(12'hABC, 12'h123, 2'b00);
        run_transfer(0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            add_word(12'($urandom), 12'($urandom), (i == 5) ? 2'b10 : 2'b00);
        end
        run_transfer(0, 1'b0);

        add_random_words(3);
        run_transfer(7, 1'b0);

        for (int r = 0; r < 4; r++) begin
            add_random_words($urandom_range(1, 24));
            run_transfer($urandom_range(0, 12), 1'b0);
        end

        abort_test(1'b0);
        abort_test(1'b1);

        add_random_words(int'(MEM_SIZE));
        run_transfer(11, 1'b1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
